issue_router: RTL and testbench

- In-order issue stage that sits between decode and the per-slot control decoder.
- Buffers a program-ordered stream of up to ISSUE_NUM instructions per cycle in a circular queue.
- Each cycle it classifies the oldest entries by opcode/funct7 and routes them into the four fixed execution slots: slot0/slot1 ALU, slot2 MDU, slot3 BRU.
- It is the producer of the per-slot opcode/func3 fields that the control decoder consumes.

---
 rtl/issue_router.sv | 147 ++++++++++++++
 tb/tb_issue_router.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_router.sv
// In-order issue stage: buffers decoded bundles in a circular queue and routes the
// oldest entries into fixed slots (slot0/1 ALU, slot2 MDU, slot3 BRU) each cycle.
module issue_router #(
  parameter int ISSUE_NUM = 4,
  parameter int QDEPTH    = 8,
  parameter int PC_W      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ISSUE_NUM-1:0]      in_valid,
  input  logic [32*ISSUE_NUM-1:0]   in_inst,
  input  logic [PC_W*ISSUE_NUM-1:0] in_pc,
  output logic                      in_ready,
  input  logic                      issue_stall,
  input  logic                      flush,
  output logic [3:0]                slot_valid,
  output logic [127:0]              slot_inst,
  output logic [4*PC_W-1:0]         slot_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {CLS_ALU, CLS_MDU, CLS_BRU} cls_e;

  function automatic cls_e classify(input logic [31:0] inst);
    cls_e c;
    c = CLS_ALU;
    if ((inst[6:0] == 7'b0110011 || inst[6:0] == 7'b0111011) && inst[31:25] == 7'b0000001)
      c = CLS_MDU;
    else if (inst[6:0] == 7'b1100011 || inst[6:0] == 7'b1101111 || inst[6:0] == 7'b1100111)
      c = CLS_BRU;
    return c;
  endfunction

  logic [PTR_W-1:0]  head, tail;
  logic [31:0]       q_inst [QDEPTH];
  logic [PC_W-1:0]   q_pc   [QDEPTH];

  logic              accept;
  logic [CNT_W-1:0]  enq_n, deq_n, sel_cnt, avail;
  logic [3:0]        sel_valid;
  logic [3:0][31:0]  sel_inst;
  logic [3:0][PC_W-1:0] sel_pc;

  // Space for a full-width bundle is judged on the registered count only.
  assign in_ready = (CNT_W'(QDEPTH) - q_count) >= CNT_W'(ISSUE_NUM);
  assign accept   = in_ready & (|in_valid);
  assign deq_n    = issue_stall ? '0 : sel_cnt;
  assign avail    = (q_count > CNT_W'(4)) ? CNT_W'(4) : q_count;

  always_comb begin
    enq_n = '0;
    for (int i = 0; i < ISSUE_NUM; i++)
      enq_n = enq_n + CNT_W'(in_valid[i]);
    if (!accept)
      enq_n = '0;
  end

  // Age-ordered walk: stop at the first entry that cannot be placed or after a branch,
  // so the issued group is always a contiguous prefix of the queue.
  always_comb begin : select
    logic             done;
    logic             found;
    logic [1:0]       tgt;
    logic [PTR_W-1:0] idx;
    cls_e             cls;
    sel_valid = '0;
    sel_inst  = '0;
    sel_pc    = '0;
    sel_cnt   = '0;
    done      = 1'b0;
    found     = 1'b0;
    tgt       = 2'd0;
    idx       = '0;
    cls       = CLS_ALU;
    for (int k = 0; k < 4; k++) begin
      idx   = head + PTR_W'(k);
      cls   = classify(q_inst[idx]);
      found = 1'b0;
      tgt   = 2'd0;
      if (!done && CNT_W'(k) < avail) begin
        case (cls)
          CLS_MDU: begin found = !sel_valid[2]; tgt = 2'd2; end
          CLS_BRU: begin found = !sel_valid[3]; tgt = 2'd3; end
          default: begin
            if (!sel_valid[0]) begin found = 1'b1; tgt = 2'd0; end
            else if (!sel_valid[1]) begin found = 1'b1; tgt = 2'd1; end
          end
        endcase
        if (!found) begin
          done = 1'b1;
        end else begin
          sel_valid[tgt] = 1'b1;
          sel_inst[tgt]  = q_inst[idx];
          sel_pc[tgt]    = q_pc[idx];
          sel_cnt        = sel_cnt + CNT_W'(1);
          if (cls == CLS_BRU)
            done = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      for (int i = 0; i < ISSUE_NUM; i++) begin
        if (in_valid[i]) begin
          q_inst[tail + PTR_W'(i)] <= in_inst[32*i +: 32];
          q_pc[tail + PTR_W'(i)]   <= in_pc[PC_W*i +: PC_W];
        end
      end
    end
  end

  // Flush wins over enqueue, dequeue and stall; unselected slots keep stale inst/pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      q_count    <= '0;
      slot_valid <= '0;
      slot_inst  <= '0;
      slot_pc    <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      q_count    <= '0;
      slot_valid <= '0;
    end else begin
      tail    <= tail + PTR_W'(enq_n);
      q_count <= q_count + enq_n - deq_n;
      if (!issue_stall) begin
        head       <= head + PTR_W'(sel_cnt);
        slot_valid <= sel_valid;
        for (int i = 0; i < 4; i++) begin
          if (sel_valid[i]) begin
            slot_inst[32*i +: 32]   <= sel_inst[i];
            slot_pc[PC_W*i +: PC_W] <= sel_pc[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_router.sv
// Self-checking bench for issue_router: directed scenarios plus a randomized stream
// checked against a queue-based reference model.
module tb_issue_router;

  localparam int PC_W = 64;
  localparam logic [31:0] ADD = 32'h00000033;
  localparam logic [31:0] MUL = 32'h02000033;
  localparam logic [31:0] BEQ = 32'h00000063;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [127:0] in_inst;
  logic [255:0] in_pc;
  logic         in_ready;
  logic         issue_stall;
  logic         flush;
  logic [3:0]   slot_valid;
  logic [127:0] slot_inst;
  logic [255:0] slot_pc;
  logic [3:0]   q_count;

  int n_pass  = 0;
  int n_total = 0;

  issue_router #(.ISSUE_NUM(4), .QDEPTH(8), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .issue_stall(issue_stall), .flush(flush),
    .slot_valid(slot_valid), .slot_inst(slot_inst), .slot_pc(slot_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n === 1'b1)
      assert ((in_valid & (in_valid + 4'd1)) == 4'd0)
        else $error("[TB] non-contiguous in_valid %b", in_valid);

  // Spec classes: 0 = ALU, 1 = MDU, 2 = BRU.
  function automatic int cls_of(input logic [31:0] ins);
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h3B) && ins[31:25] == 7'h01) return 1;
    if (ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h67) return 2;
    return 0;
  endfunction

  task automatic set_bundle(input int n, input logic [31:0] i0, i1, i2, i3, input logic [63:0] base);
    logic [31:0] ins [4];
    ins = '{i0, i1, i2, i3};
    in_valid = '0;
    in_inst  = '0;
    in_pc    = '0;
    for (int k = 0; k < n; k++) begin
      in_valid[k]         = 1'b1;
      in_inst[32*k +: 32] = ins[k];
      in_pc[64*k +: 64]   = base + 64'(4*k);
    end
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0; issue_stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (q_count !== 4'd0) $display("[TB] FAIL reset_q_count got %0d want 0", q_count); else n_pass++;
    n_total++; if (slot_valid !== 4'd0) $display("[TB] FAIL reset_slot_valid got %b want 0000", slot_valid); else n_pass++;
    n_total++; if (slot_inst !== '0 || slot_pc !== '0) $display("[TB] FAIL reset_slot_data got %h/%h want 0", slot_inst, slot_pc); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_alu_pairs();
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h0);
    @(negedge clk); idle();
    n_total++; if (q_count !== 4'd4) $display("[TB] FAIL alu_q_after_enq got %0d want 4", q_count); else n_pass++;
    n_total++; if (slot_valid !== 4'b0000) $display("[TB] FAIL alu_latency got %b want 0000", slot_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b0011) $display("[TB] FAIL alu_grp1_valid got %b want 0011", slot_valid); else n_pass++;
    n_total++; if (slot_pc[63:0] !== 64'h0 || slot_pc[127:64] !== 64'h4) $display("[TB] FAIL alu_grp1_pc got %h/%h want 0/4", slot_pc[63:0], slot_pc[127:64]); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b0011) $display("[TB] FAIL alu_grp2_valid got %b want 0011", slot_valid); else n_pass++;
    n_total++; if (slot_pc[63:0] !== 64'h8 || slot_pc[127:64] !== 64'hC) $display("[TB] FAIL alu_grp2_pc got %h/%h want 8/c", slot_pc[63:0], slot_pc[127:64]); else n_pass++;
    n_total++; if (slot_inst[63:0] !== {ADD, ADD}) $display("[TB] FAIL alu_grp2_inst got %h want %h", slot_inst[63:0], {ADD, ADD}); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b0000 || q_count !== 4'd0) $display("[TB] FAIL alu_drained got %b/%0d want 0000/0", slot_valid, q_count); else n_pass++;
  endtask

  task automatic test_mixed();
    set_bundle(4, ADD, MUL, BEQ, ADD, 64'h0);
    @(negedge clk); idle();
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b1101) $display("[TB] FAIL mixed_grp1_valid got %b want 1101", slot_valid); else n_pass++;
    n_total++; if (slot_pc[63:0] !== 64'h0 || slot_pc[191:128] !== 64'h4 || slot_pc[255:192] !== 64'h8)
      $display("[TB] FAIL mixed_grp1_pc got %h/%h/%h want 0/4/8", slot_pc[63:0], slot_pc[191:128], slot_pc[255:192]); else n_pass++;
    n_total++; if (slot_inst[31:0] !== ADD || slot_inst[95:64] !== MUL || slot_inst[127:96] !== BEQ)
      $display("[TB] FAIL mixed_grp1_inst got %h want %h", slot_inst, {BEQ, MUL, 32'h0, ADD}); else n_pass++;
    n_total++; if (q_count !== 4'd1) $display("[TB] FAIL mixed_q_count got %0d want 1", q_count); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b0001 || slot_pc[63:0] !== 64'hC) $display("[TB] FAIL mixed_grp2 got %b@%h want 0001@c", slot_valid, slot_pc[63:0]); else n_pass++;
  endtask

  task automatic test_stall();
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h200);
    @(negedge clk); idle();
    @(negedge clk);
    issue_stall = 1'b1;
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h300);
    @(negedge clk);
    n_total++; if (q_count !== 4'd6 || in_ready !== 1'b0) $display("[TB] FAIL stall_fill got %0d/%b want 6/0", q_count, in_ready); else n_pass++;
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h400);
    @(negedge clk);
    n_total++; if (q_count !== 4'd6) $display("[TB] FAIL stall_reject got %0d want 6", q_count); else n_pass++;
    n_total++; if (slot_valid !== 4'b0011 || slot_pc[63:0] !== 64'h200 || slot_pc[127:64] !== 64'h204)
      $display("[TB] FAIL stall_frozen got %b %h/%h want 0011 200/204", slot_valid, slot_pc[63:0], slot_pc[127:64]); else n_pass++;
    idle(); issue_stall = 1'b0;
    @(negedge clk);
    n_total++; if (slot_pc[63:0] !== 64'h208 || slot_pc[127:64] !== 64'h20C || q_count !== 4'd4 || in_ready !== 1'b1)
      $display("[TB] FAIL stall_release1 got %h/%h q=%0d rdy=%b want 208/20c q=4 rdy=1", slot_pc[63:0], slot_pc[127:64], q_count, in_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_pc[63:0] !== 64'h300 || slot_pc[127:64] !== 64'h304 || q_count !== 4'd2)
      $display("[TB] FAIL stall_release2 got %h/%h q=%0d want 300/304 q=2", slot_pc[63:0], slot_pc[127:64], q_count); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_pc[63:0] !== 64'h308 || slot_pc[127:64] !== 64'h30C || q_count !== 4'd0)
      $display("[TB] FAIL stall_release3 got %h/%h q=%0d want 308/30c q=0", slot_pc[63:0], slot_pc[127:64], q_count); else n_pass++;
    @(negedge clk);
    n_total++; if (slot_valid !== 4'b0000) $display("[TB] FAIL stall_drained got %b want 0000", slot_valid); else n_pass++;
  endtask

  task automatic test_flush();
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h500);
    @(negedge clk);
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h510);
    @(negedge clk);
    n_total++; if (q_count !== 4'd6 || slot_valid !== 4'b0011) $display("[TB] FAIL flush_setup got %0d/%b want 6/0011", q_count, slot_valid); else n_pass++;
    flush = 1'b1; issue_stall = 1'b1;
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h520);
    @(negedge clk);
    n_total++; if (q_count !== 4'd0 || slot_valid !== 4'b0000 || in_ready !== 1'b1)
      $display("[TB] FAIL flush_clear got q=%0d sv=%b rdy=%b want 0/0000/1", q_count, slot_valid, in_ready); else n_pass++;
    issue_stall = 1'b0;
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h530);
    @(negedge clk);
    n_total++; if (q_count !== 4'd0) $display("[TB] FAIL flush_drops_enq got %0d want 0", q_count); else n_pass++;
    flush = 1'b0; idle();
    @(negedge clk);
    n_total++; if (q_count !== 4'd0 || slot_valid !== 4'b0000) $display("[TB] FAIL flush_after got %0d/%b want 0/0000", q_count, slot_valid); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] pool [12];
    logic [31:0] prog [24];
    ent_t        mq [$];
    logic [3:0]  exp_sv;
    logic [31:0] exp_inst [4];
    logic [63:0] exp_pc [4];
    logic [63:0] next_pc;
    bit          grp_new, stall, rdy, finished;
    int          sent, n;
    pool = '{32'h00000033, 32'h02000033, 32'h0200003B, 32'h0000003B, 32'h40000033, 32'h00000063,
             32'h0000006F, 32'h00000067, 32'h00002003, 32'h00002023, 32'h000000B7, 32'h00000073};
    for (int i = 0; i < 24; i++) prog[i] = pool[$urandom_range(0, 11)];
    exp_sv = '0; next_pc = 64'h1000; grp_new = 0; sent = 0; finished = 0;
    for (int s = 0; s < 4; s++) begin exp_inst[s] = '0; exp_pc[s] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_total++; if (slot_valid !== exp_sv) $display("[TB] FAIL stream_valid cyc %0d got %b want %b", cyc, slot_valid, exp_sv); else n_pass++;
      n_total++; if (q_count !== 4'(mq.size())) $display("[TB] FAIL stream_q_count cyc %0d got %0d want %0d", cyc, q_count, mq.size()); else n_pass++;
      n_total++; if (in_ready !== ((8 - mq.size()) >= 4)) $display("[TB] FAIL stream_in_ready cyc %0d got %b want %b", cyc, in_ready, (8 - mq.size()) >= 4); else n_pass++;
      for (int s = 0; s < 4; s++) begin
        if (exp_sv[s]) begin
          n_total++; if (slot_inst[32*s +: 32] !== exp_inst[s] || slot_pc[64*s +: 64] !== exp_pc[s])
            $display("[TB] FAIL stream_slot%0d cyc %0d got %h@%h want %h@%h", s, cyc, slot_inst[32*s +: 32], slot_pc[64*s +: 64], exp_inst[s], exp_pc[s]);
          else n_pass++;
        end
      end
      if (grp_new) begin
        logic [63:0] pcs [$];
        bit order_ok, br_ok;
        order_ok = 1; br_ok = 1;
        for (int s = 0; s < 4; s++) if (slot_valid[s]) pcs.push_back(slot_pc[64*s +: 64]);
        if (slot_valid[3])
          for (int s = 0; s < 3; s++) if (slot_valid[s] && slot_pc[64*s +: 64] > slot_pc[255:192]) br_ok = 0;
        pcs.sort();
        foreach (pcs[j]) begin
          if (pcs[j] !== next_pc) order_ok = 0;
          next_pc = next_pc + 64'd4;
        end
        n_total++; if (!order_ok) $display("[TB] FAIL stream_order cyc %0d got first %h want %h", cyc, pcs[0], next_pc - 64'(4*pcs.size())); else n_pass++;
        n_total++; if (!br_ok) $display("[TB] FAIL stream_branch_younger cyc %0d got br@%h want oldest-last", cyc, slot_pc[255:192]); else n_pass++;
      end
      if (sent == 24 && mq.size() == 0) begin finished = 1; break; end
      stall = ($urandom_range(0, 3) == 0);
      n = 0;
      if (sent < 24 && $urandom_range(0, 3) != 0) begin
        n = $urandom_range(1, 4);
        if (n > 24 - sent) n = 24 - sent;
      end
      in_valid = '0;
      for (int k = 0; k < n; k++) begin
        in_valid[k] = 1'b1;
        in_inst[32*k +: 32] = prog[sent + k];
        in_pc[64*k +: 64]   = 64'h1000 + 64'(4*(sent + k));
      end
      issue_stall = stall;
      rdy = (8 - mq.size()) >= 4;
      grp_new = 0;
      if (!stall) begin
        bit used [4];
        int take;
        take = 0; exp_sv = '0;
        for (int j = 0; j < 4; j++) used[j] = 0;
        for (int k = 0; k < mq.size() && k < 4; k++) begin
          int c, s;
          c = cls_of(mq[k].inst); s = -1;
          if (c == 1) begin if (!used[2]) s = 2; end
          else if (c == 2) begin if (!used[3]) s = 3; end
          else begin if (!used[0]) s = 0; else if (!used[1]) s = 1; end
          if (s < 0) break;
          used[s] = 1; exp_sv[s] = 1'b1; exp_inst[s] = mq[k].inst; exp_pc[s] = mq[k].pc;
          take++;
          if (c == 2) break;
        end
        repeat (take) void'(mq.pop_front());
        grp_new = (exp_sv != 4'd0);
      end
      if (rdy) begin
        for (int k = 0; k < n; k++) mq.push_back('{prog[sent + k], 64'h1000 + 64'(4*(sent + k))});
        sent += n;
      end
      @(negedge clk);
    end
    n_total++; if (!finished || next_pc !== 64'h1060)
      $display("[TB] FAIL stream_complete got done=%0d next_pc=%h want 1/1060", finished, next_pc); else n_pass++;
    idle(); issue_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    issue_stall = 1'b1;
    set_bundle(4, ADD, ADD, ADD, ADD, 64'h700);
    @(negedge clk);
    set_bundle(1, ADD, ADD, ADD, ADD, 64'h710);
    @(negedge clk); idle();
    n_total++; if (q_count !== 4'd5 || in_ready !== 1'b0) $display("[TB] FAIL areset_setup got %0d/%b want 5/0", q_count, in_ready); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (q_count !== 4'd0 || slot_valid !== 4'd0) $display("[TB] FAIL areset_immediate got %0d/%b want 0/0000", q_count, slot_valid); else n_pass++;
    n_total++; if (slot_inst !== '0 || slot_pc !== '0) $display("[TB] FAIL areset_slot_data got %h/%h want 0", slot_inst, slot_pc); else n_pass++;
    @(negedge clk);
    issue_stall = 1'b0; rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1 || q_count !== 4'd0) $display("[TB] FAIL areset_release got %b/%0d want 1/0", in_ready, q_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_pairs();
    test_mixed();
    test_stall();
    test_flush();
    test_stream();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
